// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared definitions for the instruction-fetch AXI read bridge:
// fixed AR beat fields and the AR channel FSM state encoding.
package inst_axi_rd_bridge_pkg;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    localparam logic [7:0] ARLEN_SINGLE = 8'd0;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Bridges the IF stage's sram-like fetch port onto an AXI4 read master (AR/R only),
// tracking accepted-but-unreturned fetches so address and data phases can overlap.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'h0,
    parameter int unsigned CNT_W           = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  axi_arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    ar_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      araddr_q;
    logic [1:0]       size_q;
    logic             addr_ok;
    logic             data_ok;

    // The full check uses the registered count, so a same-cycle data_ok never frees a slot.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        addr_ok = 1'b0;
        unique case (state_q)
            AR_IDLE: begin
                addr_ok = inst_sram_req & ~inst_sram_wr & (cnt_q < MAX_CNT);
                if (addr_ok) state_d = AR_SEND;
            end
            AR_SEND: begin
                if (arready) state_d = AR_IDLE;
            end
            default: state_d = AR_IDLE;
        endcase
    end

    // A response with nothing outstanding is drained silently instead of underflowing.
    assign data_ok = rvalid & (cnt_q != '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) state_q <= AR_IDLE;
        else       state_q <= state_d;
    end

    // AR fields latch only on acceptance, which keeps them stable for the whole AR_SEND phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= '0;
            size_q   <= '0;
        end else if (addr_ok) begin
            araddr_q <= inst_sram_addr;
            size_q   <= inst_sram_size;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            unique case ({addr_ok, data_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign arvalid = (state_q == AR_SEND);
    assign araddr  = araddr_q;
    assign arsize  = {1'b0, size_q};
    assign arlen   = ARLEN_SINGLE;
    assign arburst = ARBURST_INCR;
    assign axi_arid = arvalid ? ARID_VAL : 4'h0;

    assign rready            = 1'b1;
    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok;
    assign inst_sram_rdata   = rdata;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed table-driven bench for inst_axi_rd_bridge plus a hand-written
// full/drain sequence driven by a simple AXI slave stand-in.
module tb_inst_axi_rd_bridge;

    localparam logic [3:0] ARID = 4'hA;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok, data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic        rvalid, rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(
        .MAX_OUTSTANDING(2),
        .ARID_VAL       (ARID),
        .CNT_W          (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (req),
        .inst_sram_wr     (wr),
        .inst_sram_size   (size),
        .inst_sram_addr   (addr),
        .inst_sram_addr_ok(addr_ok),
        .inst_sram_data_ok(data_ok),
        .inst_sram_rdata  (sram_rdata),
        .axi_arid         (arid),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .rready           (rready)
    );

    typedef struct {
        bit          rst;
        bit          req;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        bit          arready;
        bit          rvalid;
        logic [31:0] rdata;
        bit          e_addr_ok;
        bit          e_data_ok;
        bit          e_arvalid;
        logic [31:0] e_araddr;
        logic [2:0]  e_arsize;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit q, input bit w, input logic [1:0] s,
                       input logic [31:0] a, input bit ar, input bit rv, input logic [31:0] rd,
                       input bit eok, input bit edok, input bit earv,
                       input logic [31:0] earaddr, input logic [2:0] earsize);
        vec_t v;
        v.rst = r; v.req = q; v.wr = w; v.size = s; v.addr = a;
        v.arready = ar; v.rvalid = rv; v.rdata = rd;
        v.e_addr_ok = eok; v.e_data_ok = edok; v.e_arvalid = earv;
        v.e_araddr = earaddr; v.e_arsize = earsize;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit q, input logic [31:0] a, input bit ar,
                         input bit rv, input logic [31:0] rd);
        req = q; wr = 1'b0; size = 2'd2; addr = a;
        arready = ar; rvalid = rv; rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset arvalid", 32'(arvalid), 32'd0);
        check("reset araddr", araddr, 32'h0);
        check("reset addr_ok", 32'(addr_ok), 32'd0);
        check("reset data_ok", 32'(data_ok), 32'd0);
        check("reset rready", 32'(rready), 32'd1);
        next_cycle();

        // single fetch, then a stray response
        add(0,1,0,2,32'h1C000000,0,0,32'h0,        1,0,0,32'h00000000,3'd0);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h1C000000,3'd2);
        add(0,0,0,0,32'h0,       0,0,32'h0,        0,0,0,32'h1C000000,3'd2);
        add(0,0,0,0,32'h0,       0,1,32'h02800C21, 0,1,0,32'h1C000000,3'd2);
        add(0,0,0,0,32'h0,       0,1,32'hDEADBEEF, 0,0,0,32'h1C000000,3'd2);
        // AR backpressure for five cycles; IF keeps asking for something else meanwhile
        add(0,1,0,2,32'h1C000004,0,0,32'h0,        1,0,0,32'h1C000000,3'd2);
        for (int k = 0; k < 5; k++)
            add(0,1,0,2,32'h1C000008,0,0,32'h0,    0,0,1,32'h1C000004,3'd2);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h1C000004,3'd2);
        // accept and return in the same cycle with one outstanding: count stays 1
        add(0,1,0,2,32'h1C000010,0,1,32'h11111111, 1,1,0,32'h1C000004,3'd2);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h1C000010,3'd2);
        add(0,0,0,0,32'h0,       0,1,32'h22222222, 0,1,0,32'h1C000010,3'd2);
        add(0,0,0,0,32'h0,       0,1,32'h55555555, 0,0,0,32'h1C000010,3'd2);
        // fill both slots, third request stalls until the cycle after the first data_ok
        add(0,1,0,2,32'h20000000,0,0,32'h0,        1,0,0,32'h1C000010,3'd2);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h20000000,3'd2);
        add(0,1,0,2,32'h20000004,0,0,32'h0,        1,0,0,32'h20000000,3'd2);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h20000004,3'd2);
        add(0,1,0,2,32'h20000008,0,0,32'h0,        0,0,0,32'h20000004,3'd2);
        add(0,1,0,2,32'h20000008,0,0,32'h0,        0,0,0,32'h20000004,3'd2);
        add(0,1,0,2,32'h20000008,0,1,32'h33333333, 0,1,0,32'h20000004,3'd2);
        add(0,1,0,2,32'h20000008,0,0,32'h0,        1,0,0,32'h20000004,3'd2);
        add(0,0,0,0,32'h0,       0,0,32'h0,        0,0,1,32'h20000008,3'd2);
        // reset while in AR_SEND with two outstanding
        add(1,1,0,2,32'h2000000C,0,0,32'h0,        0,0,1,32'h20000008,3'd2);
        add(0,0,0,0,32'h0,       0,0,32'h0,        0,0,0,32'h00000000,3'd0);
        add(0,0,0,0,32'h0,       0,1,32'h44444444, 0,0,0,32'h00000000,3'd0);
        // write requests are never accepted; a following read is
        add(0,1,1,1,32'h1C000020,0,0,32'h0,        0,0,0,32'h00000000,3'd0);
        add(0,1,0,1,32'h1C000020,0,0,32'h0,        1,0,0,32'h00000000,3'd0);
        add(0,0,0,0,32'h0,       1,0,32'h0,        0,0,1,32'h1C000020,3'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            req     = vecs[i].req;
            wr      = vecs[i].wr;
            size    = vecs[i].size;
            addr    = vecs[i].addr;
            arready = vecs[i].arready;
            rvalid  = vecs[i].rvalid;
            rdata   = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("row%0d addr_ok", i), 32'(addr_ok), 32'(vecs[i].e_addr_ok));
            check($sformatf("row%0d data_ok", i), 32'(data_ok), 32'(vecs[i].e_data_ok));
            check($sformatf("row%0d arvalid", i), 32'(arvalid), 32'(vecs[i].e_arvalid));
            check($sformatf("row%0d araddr", i), araddr, vecs[i].e_araddr);
            check($sformatf("row%0d arsize", i), 32'(arsize), 32'(vecs[i].e_arsize));
            check($sformatf("row%0d arid", i), 32'(arid), vecs[i].e_arvalid ? 32'(ARID) : 32'd0);
            check($sformatf("row%0d rdata", i), sram_rdata, vecs[i].rdata);
            check($sformatf("row%0d rready", i), 32'(rready), 32'd1);
            check($sformatf("row%0d arlen", i), 32'(arlen), 32'd0);
            check($sformatf("row%0d arburst", i), 32'(arburst), 32'd1);
            next_cycle();
        end

        // Hand-written: one fetch already outstanding; slave grants arready only after seeing arvalid.
        drive(1'b1, 32'h30000000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("seq accept second", 32'(addr_ok), 32'd1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 5 && !seen; c++) begin
                @(negedge clk);
                if (arvalid) seen = 1'b1;
                else next_cycle();
            end
            check("seq arvalid within budget", 32'(seen), 32'd1);
        end
        check("seq araddr", araddr, 32'h30000000);
        check("seq arid", 32'(arid), 32'(ARID));
        next_cycle();
        arready = 1'b1;
        @(negedge clk);
        check("seq arvalid at handshake", 32'(arvalid), 32'd1);
        next_cycle();
        drive(1'b1, 32'h30000004, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("seq full blocks addr_ok", 32'(addr_ok), 32'd0);
        check("seq arvalid dropped", 32'(arvalid), 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h66666666);
        @(negedge clk);
        check("seq first data_ok", 32'(data_ok), 32'd1);
        check("seq first rdata", sram_rdata, 32'h66666666);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77777777);
        @(negedge clk);
        check("seq second data_ok", 32'(data_ok), 32'd1);
        check("seq second rdata", sram_rdata, 32'h77777777);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h88888888);
        @(negedge clk);
        check("seq drained data_ok", 32'(data_ok), 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
